// File: rtl/keccak_padder.sv
// rtl/keccak_padder.sv - Keccak pad10*1 byte-level padder feeding the keccak core
//
// Purpose:
//   Takes a byte-granular W-bit message stream and applies Keccak pad10*1
//   (0x01 ... 0x80) for a rate of RATE_WORDS words. It emits whole rate
//   blocks to the keccak core. When the message ends exactly on a block
//   boundary, it appends an extra padding block.
//
// Ports:
//   Clock        in   clock
//   Reset        in   asynchronous active-high reset
//   Start        in   synchronous clear, begins a new message
//   In_data      in   message word, byte k at bits [8k+7:8k]
//   In_valid     in   In_data valid
//   In_last      in   final message word (qualified by In_valid)
//   In_bytes     in   valid bytes in final word, 0..8 (values above 8 act as 8)
//   In_ready     out  padder accepts In_data this cycle
//   Din          out  word to core
//   Din_valid    out  Din holds a word
//   Last_block   out  Din is the final word of the final block
//   Buffer_full  in   core input buffer full, no transfer this cycle
//   Done         out  final word transferred, held until Start or Reset

module keccak_padder #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] In_data,
  input  logic         In_valid,
  input  logic         In_last,
  input  logic [3:0]   In_bytes,
  output logic         In_ready,
  output logic [W-1:0] Din,
  output logic         Din_valid,
  output logic         Last_block,
  input  logic         Buffer_full,
  output logic         Done
);

  localparam int NB  = W / 8;
  localparam int WCW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;

  localparam logic [W-1:0] PAD_FIRST = W'(1);
  localparam logic [W-1:0] PAD_FINAL = {8'h80, {(W-8){1'b0}}};

  typedef enum logic [2:0] {
    ST_ABSORB,
    ST_PADHEAD,
    ST_PAD,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]   din_q, din_d;
  logic           din_valid_q, din_valid_d;
  logic           last_block_q, last_block_d;
  logic           done_q, done_d;

  logic           out_xfer;
  logic           load_ok;
  logic           last_pos;
  logic           ready_int;
  logic           load;
  logic [W-1:0]   load_word;
  logic           load_last;
  logic [W-1:0]   last_word;
  logic           last_full;
  int             n_eff;

  assign out_xfer = din_valid_q & ~Buffer_full;
  // The output register can take a new word when it is empty or drains this cycle.
  assign load_ok  = ~din_valid_q | out_xfer;
  assign last_pos = (wcnt_q == WCW'(RATE_WORDS - 1));

  // Final-word formatting: keep bytes below n, place 0x01 at byte n, zero the rest.
  always_comb begin
    last_word = '0;
    n_eff     = (int'(In_bytes) > NB) ? NB : int'(In_bytes);
    for (int k = 0; k < NB; k++) begin
      if (k < n_eff) begin
        last_word[8*k +: 8] = In_data[8*k +: 8];
      end else if (k == n_eff) begin
        last_word[8*k +: 8] = 8'h01;
      end else begin
        last_word[8*k +: 8] = 8'h00;
      end
    end
    last_full = (n_eff >= NB);
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    din_d        = din_q;
    din_valid_d  = din_valid_q;
    last_block_d = last_block_q;
    done_d       = done_q;
    ready_int    = 1'b0;
    load         = 1'b0;
    load_word    = '0;
    load_last    = 1'b0;

    case (state_q)
      ST_ABSORB: begin
        ready_int = load_ok;
        if (In_valid && ready_int) begin
          load = 1'b1;
          if (!In_last) begin
            load_word = In_data;
          end else if (last_full) begin
            // Full final word: the 0x01 byte must go into a following word.
            load_word = In_data;
            state_d   = ST_PADHEAD;
          end else if (last_pos) begin
            load_word = last_word | PAD_FINAL;
            load_last = 1'b1;
            state_d   = ST_FLUSH;
          end else begin
            load_word = last_word;
            state_d   = ST_PAD;
          end
        end
      end

      ST_PADHEAD: begin
        if (load_ok) begin
          load = 1'b1;
          if (last_pos) begin
            load_word = PAD_FIRST | PAD_FINAL;
            load_last = 1'b1;
            state_d   = ST_FLUSH;
          end else begin
            load_word = PAD_FIRST;
            state_d   = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        if (load_ok) begin
          load = 1'b1;
          if (last_pos) begin
            load_word = PAD_FINAL;
            load_last = 1'b1;
            state_d   = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (out_xfer) begin
          din_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
      end

      default: begin
        state_d = ST_ABSORB;
      end
    endcase

    if (load) begin
      din_d        = load_word;
      din_valid_d  = 1'b1;
      last_block_d = load_last;
      wcnt_d       = last_pos ? '0 : wcnt_q + 1'b1;
    end else if (out_xfer) begin
      din_valid_d  = 1'b0;
      last_block_d = 1'b0;
    end

    // Start discards any held word and anything presented alongside it.
    if (Start) begin
      state_d      = ST_ABSORB;
      wcnt_d       = '0;
      din_d        = '0;
      din_valid_d  = 1'b0;
      last_block_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_ABSORB;
      wcnt_q       <= '0;
      din_q        <= '0;
      din_valid_q  <= 1'b0;
      last_block_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      din_q        <= din_d;
      din_valid_q  <= din_valid_d;
      last_block_q <= last_block_d;
      done_q       <= done_d;
    end
  end

  assign In_ready   = ready_int & ~Start & ~Reset;
  assign Din        = din_q;
  assign Din_valid  = din_valid_q;
  assign Last_block = last_block_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_keccak_padder.sv
// tb/tb_keccak_padder.sv - self-checking bench for keccak_padder

module tb_keccak_padder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [63:0] In_data;
  logic        In_valid;
  logic        In_last;
  logic [3:0]  In_bytes;
  logic        In_ready;
  logic [63:0] Din;
  logic        Din_valid;
  logic        Last_block;
  logic        Buffer_full;
  logic        Done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] msg_q[$];

  keccak_padder #(.W(64), .RATE_WORDS(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .In_data(In_data), .In_valid(In_valid), .In_last(In_last), .In_bytes(In_bytes),
    .In_ready(In_ready), .Din(Din), .Din_valid(Din_valid), .Last_block(Last_block),
    .Buffer_full(Buffer_full), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic idle_inputs();
    Start = 0; In_valid = 0; In_last = 0; In_bytes = 0; In_data = 0; Buffer_full = 0;
  endtask

  // Sends msg_q and checks every transferred word against pad10*1 applied to the
  // byte string directly, padded out to a multiple of 128 bytes.
  task automatic run_msg(input string name, input bit do_start, input bit rnd, input int stall_at);
    logic [7:0]  p[$];
    logic [63:0] exp[$];
    logic [63:0] w, hold_din;
    logic        hold_lb;
    bit          hold;
    int          len, nw, nlast, idx, rcv, cyc, stall_n;
    len = msg_q.size();
    p = msg_q;
    p.push_back(8'h01);
    while (p.size() % 128 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    for (int i = 0; i < p.size() / 8; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = p[8*i + k];
      exp.push_back(w);
    end
    if (len == 0) begin nw = 1; nlast = 0; end
    else begin nw = (len + 7) / 8; nlast = len - 8 * (nw - 1); end
    if (do_start) begin
      @(negedge Clock); idle_inputs(); Start = 1;
      @(negedge Clock); Start = 0;
    end
    idx = 0; rcv = 0; cyc = 0; stall_n = 0; hold = 0; hold_din = '0; hold_lb = 0;
    while (rcv < exp.size() && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
      In_valid = (idx < nw) && (!rnd || $urandom_range(3) != 0);
      In_last  = (idx == nw - 1);
      w = {$urandom, $urandom};
      for (int k = 0; k < 8; k++)
        if (8*idx + k < len) w[8*k +: 8] = msg_q[8*idx + k];
      In_data = w;
      if (In_last) In_bytes = (nlast == 8 && rnd) ? 4'($urandom_range(15, 8)) : 4'(nlast);
      else         In_bytes = 4'($urandom);
      if (stall_at >= 0 && rcv == stall_at && stall_n < 5) begin
        Buffer_full = 1; stall_n++;
      end else begin
        Buffer_full = rnd ? ($urandom_range(2) == 0) : 1'b0;
      end
      #1;
      if (hold) begin
        n_cmp++;
        if (Din !== hold_din || Last_block !== hold_lb || Din_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL %s hold_stable: Din=%h lb=%b v=%b expected Din=%h lb=%b v=1",
                   name, Din, Last_block, Din_valid, hold_din, hold_lb);
        end
      end
      if (Din_valid && Buffer_full) begin
        n_cmp++;
        if (In_ready !== 1'b0) begin
          n_bad++; $display("FAIL %s ready_when_full: In_ready=%b expected 0", name, In_ready);
        end
      end
      if (Done !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL %s early_done: Done=%b expected 0", name, Done);
      end
      if (Din_valid && !Buffer_full) begin
        n_cmp++;
        if (Din !== exp[rcv]) begin
          n_bad++; $display("FAIL %s word%0d: Din=%h expected %h", name, rcv, Din, exp[rcv]);
        end
        n_cmp++;
        if (Last_block !== (rcv == exp.size() - 1)) begin
          n_bad++; $display("FAIL %s last_block%0d: got %b expected %b", name, rcv, Last_block,
                            rcv == exp.size() - 1);
        end
        rcv++;
      end
      hold     = Din_valid && Buffer_full;
      hold_din = Din;
      hold_lb  = Last_block;
      if (In_valid && In_ready) idx++;
    end
    n_cmp++;
    if (rcv != exp.size()) begin
      n_bad++; $display("FAIL %s transfer_count: got %0d expected %0d (cycle budget)", name, rcv, exp.size());
    end
    n_cmp++;
    if (idx != nw) begin
      n_bad++; $display("FAIL %s input_count: got %0d expected %0d", name, idx, nw);
    end
    @(negedge Clock); idle_inputs(); #1;
    n_cmp++;
    if (Done !== 1'b1 || Din_valid !== 1'b0 || Last_block !== 1'b0 || In_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_state: Done=%b v=%b lb=%b rdy=%b expected 1 0 0 0",
               name, Done, Din_valid, Last_block, In_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    #1;
    n_cmp++;
    if (Din !== 64'h0 || Din_valid !== 0 || Last_block !== 0 || Done !== 0 || In_ready !== 0) begin
      n_bad++;
      $display("FAIL reset_values: Din=%h v=%b lb=%b done=%b rdy=%b expected all 0",
               Din, Din_valid, Last_block, Done, In_ready);
    end
    @(negedge Clock); Reset = 0;
    #1;
    n_cmp++;
    if (In_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: In_ready=%b expected 1", In_ready);
    end
  endtask

  task automatic test_empty();
    msg_q = {};
    run_msg("empty", 1, 0, -1);
  endtask

  task automatic test_one_byte();
    msg_q = {8'hAB};
    run_msg("one_byte", 1, 0, -1);
  endtask

  task automatic test_127_bytes();
    msg_q = {};
    repeat (127) msg_q.push_back(8'hFF);
    run_msg("bytes127", 1, 0, -1);
  endtask

  task automatic test_128_bytes();
    msg_q = {};
    repeat (128) msg_q.push_back(8'($urandom));
    run_msg("bytes128", 1, 0, -1);
  endtask

  task automatic test_backpressure();
    msg_q = {};
    repeat (80) msg_q.push_back(8'($urandom));
    run_msg("backpressure", 1, 0, 7);
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      msg_q = {};
      repeat ($urandom_range(300)) msg_q.push_back(8'($urandom));
      run_msg($sformatf("random%0d", m), 1, 1, -1);
    end
  endtask

  task automatic test_reset_mid_pad();
    @(negedge Clock); idle_inputs(); Start = 1;
    @(negedge Clock); Start = 0;
    In_valid = 1; In_last = 1; In_bytes = 4'd1; In_data = 64'h0000_0000_0000_00AB;
    #1;
    n_cmp++;
    if (In_ready !== 1'b1) begin
      n_bad++; $display("FAIL midpad_accept: In_ready=%b expected 1", In_ready);
    end
    @(negedge Clock); idle_inputs();
    repeat (4) @(negedge Clock);
    #2 Reset = 1;
    #1;
    n_cmp++;
    if (Din !== 64'h0 || Din_valid !== 0 || Last_block !== 0 || Done !== 0 || In_ready !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_pad: Din=%h v=%b lb=%b done=%b rdy=%b expected all 0",
               Din, Din_valid, Last_block, Done, In_ready);
    end
    @(negedge Clock); Reset = 0;
    msg_q = {8'hCD};
    run_msg("after_reset", 0, 0, -1);
  endtask

  task automatic test_start_mid_absorb();
    @(negedge Clock); idle_inputs(); Start = 1;
    @(negedge Clock); Start = 0;
    for (int i = 0; i < 3; i++) begin
      In_valid = 1; In_last = 0; In_data = {$urandom, $urandom};
      #1;
      n_cmp++;
      if (In_ready !== 1'b1) begin
        n_bad++; $display("FAIL absorb_ready%0d: In_ready=%b expected 1", i, In_ready);
      end
      @(negedge Clock);
    end
    Start = 1; In_valid = 1; In_last = 0; In_data = {$urandom, $urandom};
    #1;
    n_cmp++;
    if (In_ready !== 1'b0) begin
      n_bad++; $display("FAIL start_blocks_input: In_ready=%b expected 0", In_ready);
    end
    @(negedge Clock); idle_inputs();
    #1;
    n_cmp++;
    if (Din !== 64'h0 || Din_valid !== 0 || Last_block !== 0 || Done !== 0) begin
      n_bad++;
      $display("FAIL start_clear: Din=%h v=%b lb=%b done=%b expected all 0",
               Din, Din_valid, Last_block, Done);
    end
    msg_q = {8'h5A};
    run_msg("after_start", 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_one_byte();
    test_127_bytes();
    test_128_bytes();
    test_backpressure();
    test_random();
    test_reset_mid_pad();
    test_start_mid_absorb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
